alu_issue_ctrl: RTL and testbench

// - Multi-cycle initiator for the 32-bit ALU: accepts one data-processing command, reads the register file, drives the ALU operand/opcode/cin inputs, captures result+carry+zero, writes back, updates NZC flags.
// - Sits between decode and the combinational ALU + register file; ALU is the responder, this block drives its interface.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_issue_ctrl_flag_reg.sv | 28 ++
 rtl/alu_issue_ctrl.sv | 178 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and opcode helpers for the ALU issue controller.
// Holds FSM state encoding, ARM data-processing opcodes and ALU opcode map.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        EX,
        WB
    } state_e;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_CMP = 4'b1010;

    // True for the data-processing ops this block can issue
    function automatic logic op_legal(input logic [3:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_AND, OP_SUB, OP_ADD,
            OP_ADC, OP_CMP: ok = 1'b1;
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // ARM op to ALU opcode: ADC reuses ADD with cin, CMP reuses SUB
    function automatic logic [3:0] alu_opcode_map(input logic [3:0] op);
        logic [3:0] code;
        code = 4'b0000;
        case (op)
            OP_ADD, OP_ADC: code = 4'b0100;
            OP_SUB, OP_CMP: code = 4'b0010;
            default:        code = 4'b0000;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_flag_reg.sv
// NZC architectural flag register.
// Loads all three flags together when load is high.
module alu_flag_reg (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic n_in,
    input  logic z_in,
    input  logic c_in,
    output logic n,
    output logic z,
    output logic c
);

    // Flag storage, cleared by reset, updated on retire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n <= 1'b0;
            z <= 1'b0;
            c <= 1'b0;
        end else if (load) begin
            n <= n_in;
            z <= z_in;
            c <= c_in;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller for the 32-bit ALU.
// Walks IDLE->RD->EX->WB per command: read RF, run ALU, write back, set NZC.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic              cmd_s,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic [REG_AW-1:0] cmd_rn,
    input  logic [REG_AW-1:0] cmd_rm,
    input  logic              cmd_use_imm,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [REG_AW-1:0] rf_ra,
    output logic [REG_AW-1:0] rf_rb,
    input  logic [DATA_W-1:0] rf_da,
    input  logic [DATA_W-1:0] rf_db,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_cout,
    input  logic              alu_zero,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_c,
    output logic              done,
    output logic              err
);

    state_e state;
    state_e state_nxt;

    logic [3:0]        op_q;
    logic              s_q;
    logic              use_imm_q;
    logic [REG_AW-1:0] rd_q;
    logic [REG_AW-1:0] rn_q;
    logic [REG_AW-1:0] rm_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] opa_q;
    logic [DATA_W-1:0] opb_q;
    logic [DATA_W-1:0] res_q;
    logic              c_q;
    logic              z_q;

    logic legal;
    logic is_cmp;
    logic flag_load;
    logic c_new;

    assign legal  = op_legal(op_q);
    assign is_cmp = (op_q == OP_CMP);
    // AND never produces a carry, whatever the ALU reports
    assign c_new  = (op_q == OP_AND) ? 1'b0 : c_q;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and per-state drive of RF/ALU/retire signals
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rf_ra     = '0;
        rf_rb     = '0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = 4'b0000;
        alu_cin   = 1'b0;
        rf_we     = 1'b0;
        rf_wa     = '0;
        rf_wd     = '0;
        done      = 1'b0;
        err       = 1'b0;
        flag_load = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = RD;
            end
            RD: begin
                rf_ra     = rn_q;
                rf_rb     = rm_q;
                state_nxt = EX;
            end
            EX: begin
                if (legal) begin
                    alu_a   = opa_q;
                    alu_b   = opb_q;
                    alu_op  = alu_opcode_map(op_q);
                    alu_cin = (op_q == OP_ADC) ? flag_c : 1'b0;
                end
                state_nxt = WB;
            end
            WB: begin
                done      = 1'b1;
                err       = !legal;
                rf_we     = legal && !is_cmp;
                rf_wa     = rd_q;
                rf_wd     = res_q;
                flag_load = legal && (s_q || is_cmp);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the command on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= 4'b0000;
            s_q       <= 1'b0;
            use_imm_q <= 1'b0;
            rd_q      <= '0;
            rn_q      <= '0;
            rm_q      <= '0;
            imm_q     <= '0;
        end else if (cmd_valid && cmd_ready) begin
            op_q      <= cmd_op;
            s_q       <= cmd_s;
            use_imm_q <= cmd_use_imm;
            rd_q      <= cmd_rd;
            rn_q      <= cmd_rn;
            rm_q      <= cmd_rm;
            imm_q     <= cmd_imm;
        end
    end

    // Latch operands at the end of RD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_q <= '0;
            opb_q <= '0;
        end else if (state == RD) begin
            opa_q <= rf_da;
            opb_q <= use_imm_q ? imm_q : rf_db;
        end
    end

    // Latch ALU result and status at the end of EX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
            c_q   <= 1'b0;
            z_q   <= 1'b0;
        end else if (state == EX) begin
            res_q <= alu_res;
            c_q   <= alu_cout;
            z_q   <= alu_zero;
        end
    end

    alu_flag_reg u_flags (
        .clk  (clk),
        .rst  (rst),
        .load (flag_load),
        .n_in (res_q[DATA_W-1]),
        .z_in (z_q),
        .c_in (c_new),
        .n    (flag_n),
        .z    (flag_z),
        .c    (flag_c)
    );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl with a behavioural ALU and 16x32 RF.
// Directed vector table plus hand sequences for hold and reset cases.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic        cmd_s;
    logic [3:0]  cmd_rd;
    logic [3:0]  cmd_rn;
    logic [3:0]  cmd_rm;
    logic        cmd_use_imm;
    logic [31:0] cmd_imm;
    logic [3:0]  rf_ra;
    logic [3:0]  rf_rb;
    logic [31:0] rf_da;
    logic [31:0] rf_db;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic        alu_cin;
    logic [31:0] alu_res;
    logic        alu_cout;
    logic        alu_zero;
    logic        flag_n;
    logic        flag_z;
    logic        flag_c;
    logic        done;
    logic        err;

    logic        rf_load;
    logic [31:0] rf [16];

    int checks;
    int errors;

    alu_issue_ctrl #(
        .DATA_W (32),
        .REG_AW (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_s       (cmd_s),
        .cmd_rd      (cmd_rd),
        .cmd_rn      (cmd_rn),
        .cmd_rm      (cmd_rm),
        .cmd_use_imm (cmd_use_imm),
        .cmd_imm     (cmd_imm),
        .rf_ra       (rf_ra),
        .rf_rb       (rf_rb),
        .rf_da       (rf_da),
        .rf_db       (rf_db),
        .rf_we       (rf_we),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_cin     (alu_cin),
        .alu_res     (alu_res),
        .alu_cout    (alu_cout),
        .alu_zero    (alu_zero),
        .flag_n      (flag_n),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: ADD with cin, SUB as a+~b+1, AND
    logic [32:0] alu_sum;
    always_comb begin
        alu_sum = 33'd0;
        case (alu_op)
            4'b0100: alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
            4'b0010: alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
            4'b0000: alu_sum = {1'b0, alu_a & alu_b};
            default: alu_sum = 33'd0;
        endcase
    end
    assign alu_res  = alu_sum[31:0];
    assign alu_cout = alu_sum[32];
    assign alu_zero = (alu_sum[31:0] == 32'd0);

    // Register file: async read, sync write, preload on rf_load
    assign rf_da = rf[rf_ra];
    assign rf_db = rf[rf_rb];
    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 16; i++) rf[i] <= 32'd0;
            rf[2]  <= 32'd5;
            rf[3]  <= 32'd7;
            rf[4]  <= 32'd3;
            rf[5]  <= 32'd0;
            rf[6]  <= 32'd9;
            rf[7]  <= 32'd9;
            rf[8]  <= 32'h0000_F0F0;
            rf[9]  <= 32'h0000_0FF0;
            rf[10] <= 32'hFFFF_FFFF;
        end else if (rf_we) begin
            rf[rf_wa] <= rf_wd;
        end
    end

    typedef struct {
        logic [3:0]  op;
        logic        s;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic        use_imm;
        logic [31:0] imm;
        logic        we;
        logic [31:0] wd;
        logic        n;
        logic        z;
        logic        c;
        logic        err;
        logic        cin;
        logic [3:0]  aop;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int wait_cyc;
        @(negedge clk);
        cmd_op      = v.op;
        cmd_s       = v.s;
        cmd_rd      = v.rd;
        cmd_rn      = v.rn;
        cmd_rm      = v.rm;
        cmd_use_imm = v.use_imm;
        cmd_imm     = v.imm;
        cmd_valid   = 1'b1;
        wait_cyc    = 0;
        while (!cmd_ready && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!cmd_ready) begin
            chk($sformatf("v%0d_accept_timeout", idx), 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk($sformatf("v%0d_rd_ready", idx), {31'd0, cmd_ready}, 32'd0);
        chk($sformatf("v%0d_rd_done", idx), {31'd0, done}, 32'd0);
        chk($sformatf("v%0d_rd_we", idx), {31'd0, rf_we}, 32'd0);
        chk($sformatf("v%0d_rd_aluop", idx), {28'd0, alu_op}, 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d_ex_done", idx), {31'd0, done}, 32'd0);
        chk($sformatf("v%0d_ex_aluop", idx), {28'd0, alu_op}, {28'd0, v.aop});
        chk($sformatf("v%0d_ex_cin", idx), {31'd0, alu_cin}, {31'd0, v.cin});
        @(negedge clk);
        chk($sformatf("v%0d_wb_done", idx), {31'd0, done}, 32'd1);
        chk($sformatf("v%0d_wb_err", idx), {31'd0, err}, {31'd0, v.err});
        chk($sformatf("v%0d_wb_we", idx), {31'd0, rf_we}, {31'd0, v.we});
        if (v.we) begin
            chk($sformatf("v%0d_wb_wa", idx), {28'd0, rf_wa}, {28'd0, v.rd});
            chk($sformatf("v%0d_wb_wd", idx), rf_wd, v.wd);
        end
        @(negedge clk);
        chk($sformatf("v%0d_done_pulse", idx), {31'd0, done}, 32'd0);
        chk($sformatf("v%0d_ready", idx), {31'd0, cmd_ready}, 32'd1);
        chk($sformatf("v%0d_flags", idx), {29'd0, flag_n, flag_z, flag_c},
            {29'd0, v.n, v.z, v.c});
    endtask

    initial begin
        int acc;
        int dn;
        int we_cnt;
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        rf_load     = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 4'd0;
        cmd_s       = 1'b0;
        cmd_rd      = 4'd0;
        cmd_rn      = 4'd0;
        cmd_rm      = 4'd0;
        cmd_use_imm = 1'b0;
        cmd_imm     = 32'd0;

        //             op      s     rd     rn     rm     imm   imm_val        we    wd              n     z     c     err   cin   aop
        vecs[0]  = '{4'b0100, 1'b1, 4'd1,  4'd2,  4'd3,  1'b0, 32'd0,        1'b1, 32'd12,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100};
        vecs[1]  = '{4'b0010, 1'b1, 4'd11, 4'd4,  4'd0,  1'b1, 32'd3,        1'b1, 32'd0,          1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010};
        vecs[2]  = '{4'b0010, 1'b1, 4'd12, 4'd4,  4'd0,  1'b1, 32'd4,        1'b1, 32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010};
        vecs[3]  = '{4'b0100, 1'b1, 4'd13, 4'd10, 4'd0,  1'b1, 32'd1,        1'b1, 32'd0,          1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100};
        vecs[4]  = '{4'b0101, 1'b1, 4'd14, 4'd5,  4'd0,  1'b1, 32'd0,        1'b1, 32'd1,          1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100};
        vecs[5]  = '{4'b1010, 1'b0, 4'd0,  4'd6,  4'd7,  1'b0, 32'd0,        1'b0, 32'd0,          1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010};
        vecs[6]  = '{4'b0000, 1'b0, 4'd15, 4'd8,  4'd9,  1'b0, 32'd0,        1'b1, 32'h0000_00F0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000};
        vecs[7]  = '{4'b1111, 1'b1, 4'd1,  4'd2,  4'd3,  1'b0, 32'd0,        1'b0, 32'd0,          1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000};
        vecs[8]  = '{4'b0000, 1'b1, 4'd0,  4'd8,  4'd9,  1'b0, 32'd0,        1'b1, 32'h0000_00F0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[9]  = '{4'b0101, 1'b1, 4'd3,  4'd2,  4'd0,  1'b1, 32'd10,       1'b1, 32'd15,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100};
        vecs[10] = '{4'b0100, 1'b0, 4'd1,  4'd1,  4'd1,  1'b0, 32'd0,        1'b1, 32'd24,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100};

        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_done_err_we", {29'd0, done, err, rf_we}, 32'd0);
        chk("rst_flags", {29'd0, flag_n, flag_z, flag_c}, 32'd0);
        chk("rst_alu", alu_a | alu_b | {27'd0, alu_op, alu_cin}, 32'd0);
        rst     = 1'b0;
        rf_load = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);
        chk("rf1_final", rf[1], 32'd24);
        chk("rf0_and", rf[0], 32'h0000_00F0);

        // cmd_valid held through busy: exactly one accept and one retire
        @(negedge clk);
        cmd_op      = 4'b1010;
        cmd_s       = 1'b0;
        cmd_rd      = 4'd0;
        cmd_rn      = 4'd6;
        cmd_rm      = 4'd7;
        cmd_use_imm = 1'b0;
        cmd_valid   = 1'b1;
        acc         = 0;
        dn          = 0;
        for (int i = 0; i < 8; i++) begin
            if (cmd_valid && cmd_ready) acc++;
            @(negedge clk);
            if (done) begin
                dn++;
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        chk("hold_accepts", acc, 32'd1);
        chk("hold_dones", dn, 32'd1);
        chk("hold_flags", {29'd0, flag_n, flag_z, flag_c}, 32'b011);

        // Reset asserted while an ADD sits in EX
        @(negedge clk);
        cmd_op      = 4'b0100;
        cmd_s       = 1'b1;
        cmd_rd      = 4'd4;
        cmd_rn      = 4'd2;
        cmd_rm      = 4'd3;
        cmd_use_imm = 1'b0;
        cmd_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rstex_in_ex", {28'd0, alu_op}, 32'h4);
        we_cnt = 0;
        rst    = 1'b1;
        #1;
        chk("rstex_async_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rstex_flags", {29'd0, flag_n, flag_z, flag_c}, 32'd0);
        if (rf_we) we_cnt++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rf_we) we_cnt++;
            if (i == 0) chk("rstex_ready_after", {31'd0, cmd_ready}, 32'd1);
        end
        chk("rstex_no_we", we_cnt, 32'd0);
        chk("rstex_rf4", rf[4], 32'd3);
        chk("rstex_flags_end", {29'd0, flag_n, flag_z, flag_c}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
